// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding, default sensor address and register
// table entry type for the camera configuration sequencer.
// Optional feature macro: CAM_CFG_READBACK_EN (adds the VERIFY state).
package cam_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_SKIP,
        ST_IDLE_DONE,
        ST_ERROR
`ifdef CAM_CFG_READBACK_EN
        , ST_VERIFY
`endif
    } cam_state_t;

    localparam logic [7:0] CAM_DEV_ADDR = 8'h42;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cam_reg_entry_t;

endpackage

// File: rtl/cam_reg_rom.sv
// cam_reg_rom: fixed sensor register table, {reg, data} per 8-bit index.
// Indices at or beyond NUM_REGS read as zero.
module cam_reg_rom
    import cam_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16
)(
    input  logic [7:0]  i_index,
    output logic [15:0] o_entry
);

    cam_reg_entry_t w_entry;

    // Table lookup with out-of-range indices forced to zero
    always_comb begin
        case (i_index)
            8'd0:    w_entry = 16'h1280;
            8'd1:    w_entry = 16'h1101;
            8'd2:    w_entry = 16'h0C04;
            8'd3:    w_entry = 16'h3E19;
            8'd4:    w_entry = 16'h703A;
            8'd5:    w_entry = 16'h7135;
            8'd6:    w_entry = 16'h7211;
            8'd7:    w_entry = 16'h73F1;
            8'd8:    w_entry = 16'hA202;
            8'd9:    w_entry = 16'h40D0;
            8'd10:   w_entry = 16'h8C00;
            8'd11:   w_entry = 16'h3A04;
            8'd12:   w_entry = 16'h1418;
            8'd13:   w_entry = 16'h4FB3;
            8'd14:   w_entry = 16'h50B3;
            8'd15:   w_entry = 16'h589E;
            default: w_entry = '0;
        endcase
        if ({24'd0, i_index} >= NUM_REGS) begin
            w_entry = '0;
        end
    end

    assign o_entry = w_entry;

endmodule

// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer: power-up sensor configuration over the I2C byte
// handshake, with per-entry retry, frame skip and capture gating.
// Optional feature macro: CAM_CFG_READBACK_EN (read back and compare
// every acknowledged write).
module cam_cfg_sequencer
    import cam_pkg::*;
#(
    parameter int unsigned NUM_REGS      = 16,
    parameter logic [7:0]  DEV_ADDR      = CAM_DEV_ADDR,
    parameter int unsigned RETRY_MAX     = 3,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned FRAME_SKIP    = 2
)(
    input  logic       clk,
    input  logic       res,
    input  logic       start,
    input  logic       vsync,
    output logic       i2c_req,
    output logic [7:0] i2c_dev,
    output logic [7:0] i2c_reg,
    output logic [7:0] i2c_wdata,
    input  logic       i2c_done,
    input  logic       i2c_nack,
`ifdef CAM_CFG_READBACK_EN
    output logic       i2c_rd,
    input  logic [7:0] i2c_rdata,
`endif
    output logic       busy,
    output logic       cam_ready,
    output logic       cfg_error,
    output logic       frame_enable
);

    localparam int unsigned   RW             = (RETRY_MAX < 4) ? 2 : $clog2(RETRY_MAX + 1);
    localparam logic [RW-1:0] LP_RETRY_MAX   = RW'(RETRY_MAX);
    localparam logic [15:0]   LP_SETTLE_LAST = (SETTLE_CYCLES > 0) ? 16'(SETTLE_CYCLES - 1) : 16'd0;
    localparam logic [15:0]   LP_FRAME_SKIP  = 16'(FRAME_SKIP);
    localparam logic [7:0]    LP_LAST_IDX    = 8'(NUM_REGS - 1);

    cam_state_t    r_state;
    logic [15:0]   r_cnt;
    logic [7:0]    r_idx;
    logic [RW-1:0] r_retry;
    logic          r_req;
    logic [7:0]    r_reg;
    logic [7:0]    r_wdata;
    logic          r_ready;
    logic          r_err;
    logic          r_fe;
    logic          r_vsync_d;
`ifdef CAM_CFG_READBACK_EN
    logic          r_rd;
`endif

    logic [15:0]   w_entry;
    logic          w_vs_rise;

    cam_reg_rom #(
        .NUM_REGS (NUM_REGS)
    ) u_rom (
        .i_index (r_idx),
        .o_entry (w_entry)
    );

    assign w_vs_rise = vsync & ~r_vsync_d;

    // Registered copy of vsync for rising-edge detection
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_vsync_d <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
        end
    end

    // Sequencer FSM; r_cnt serves as settle counter and, in SKIP, as vsync edge counter
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_retry <= '0;
            r_req   <= 1'b0;
            r_reg   <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_fe    <= 1'b0;
`ifdef CAM_CFG_READBACK_EN
            r_rd    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_cnt >= LP_SETTLE_LAST) begin
                        r_state <= ST_ISSUE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_retry <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_ISSUE: begin
                    r_reg   <= w_entry[15:8];
                    r_wdata <= w_entry[7:0];
                    r_req   <= 1'b1;
`ifdef CAM_CFG_READBACK_EN
                    r_rd    <= 1'b0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i2c_done) begin
                        r_req <= 1'b0;
                        if (i2c_nack) begin
                            if (r_retry < LP_RETRY_MAX) begin
                                r_retry <= r_retry + RW'(1);
                                r_state <= ST_ISSUE;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= ST_ERROR;
                            end
                        end else begin
`ifdef CAM_CFG_READBACK_EN
                            r_rd    <= 1'b1;
                            r_state <= ST_VERIFY;
`else
                            r_state <= ST_NEXT;
`endif
                        end
                    end
                end
`ifdef CAM_CFG_READBACK_EN
                // Entry cycle raises the read request; later cycles wait for completion
                ST_VERIFY: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (i2c_done) begin
                        r_req <= 1'b0;
                        r_rd  <= 1'b0;
                        if (i2c_nack || (i2c_rdata != r_wdata)) begin
                            if (r_retry < LP_RETRY_MAX) begin
                                r_retry <= r_retry + RW'(1);
                                r_state <= ST_ISSUE;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= ST_ERROR;
                            end
                        end else begin
                            r_state <= ST_NEXT;
                        end
                    end
                end
`endif
                ST_NEXT: begin
                    r_retry <= '0;
                    if (r_idx == LP_LAST_IDX) begin
                        r_cnt   <= '0;
                        r_state <= ST_SKIP;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_SKIP: begin
                    if (w_vs_rise) begin
                        if (r_cnt == LP_FRAME_SKIP) begin
                            r_ready <= 1'b1;
                            r_fe    <= 1'b1;
                            r_state <= ST_IDLE_DONE;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                ST_IDLE_DONE, ST_ERROR: begin
                    r_fe <= 1'b0 | (r_fe & (r_state == ST_IDLE_DONE));
                    if (start) begin
                        r_ready <= 1'b0;
                        r_err   <= 1'b0;
                        r_fe    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end
                end
                default: r_state <= ST_SETTLE;
            endcase
        end
    end

    assign busy         = ~res & (r_state != ST_IDLE_DONE) & (r_state != ST_ERROR);
    assign i2c_req      = r_req;
    assign i2c_dev      = DEV_ADDR;
    assign i2c_reg      = r_reg;
    assign i2c_wdata    = r_wdata;
    assign cam_ready    = r_ready;
    assign cfg_error    = r_err;
    assign frame_enable = r_fe;
`ifdef CAM_CFG_READBACK_EN
    assign i2c_rd       = r_rd;
`endif

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// tb_cam_cfg_sequencer: randomized I2C responder and vsync stimulus checked
// against a transaction-list model built from the register table and the
// retry rules. Set CAM_CFG_READBACK_EN to cover the read-back variant.
`timescale 1ns/1ps
module tb_cam_cfg_sequencer;

    localparam int          NREG      = 16;
    localparam int          RETRY_MAX = 3;
    localparam int          SETTLE    = 1000;
    localparam int          FSKIP     = 2;
    localparam logic [7:0]  DEV       = 8'h42;
    localparam int          BUDGET    = 6000;

    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       start = 1'b0;
    logic       vsync = 1'b0;
    logic       i2c_done = 1'b0;
    logic       i2c_nack = 1'b0;
    logic       i2c_req;
    logic [7:0] i2c_dev;
    logic [7:0] i2c_reg;
    logic [7:0] i2c_wdata;
    logic       busy;
    logic       cam_ready;
    logic       cfg_error;
    logic       frame_enable;
`ifdef CAM_CFG_READBACK_EN
    logic       i2c_rd;
    logic [7:0] i2c_rdata = 8'h00;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] tbl [NREG] = '{
        16'h1280, 16'h1101, 16'h0C04, 16'h3E19, 16'h703A, 16'h7135, 16'h7211, 16'h73F1,
        16'hA202, 16'h40D0, 16'h8C00, 16'h3A04, 16'h1418, 16'h4FB3, 16'h50B3, 16'h589E
    };

    txn_t exp_q[$];
    bit   exp_err;
    int   nack_idx = -1;
    int   nack_cnt = 0;
    int   wr_seen [NREG];
`ifdef CAM_CFG_READBACK_EN
    int   bad_idx = -1;
    int   bad_cnt = 0;
    int   rd_seen [NREG];
`endif

    always #5 clk = ~clk;

    cam_cfg_sequencer #(
        .NUM_REGS      (NREG),
        .DEV_ADDR      (DEV),
        .RETRY_MAX     (RETRY_MAX),
        .SETTLE_CYCLES (SETTLE),
        .FRAME_SKIP    (FSKIP)
    ) dut (
        .clk          (clk),
        .res          (res),
        .start        (start),
        .vsync        (vsync),
        .i2c_req      (i2c_req),
        .i2c_dev      (i2c_dev),
        .i2c_reg      (i2c_reg),
        .i2c_wdata    (i2c_wdata),
        .i2c_done     (i2c_done),
        .i2c_nack     (i2c_nack),
`ifdef CAM_CFG_READBACK_EN
        .i2c_rd       (i2c_rd),
        .i2c_rdata    (i2c_rdata),
`endif
        .busy         (busy),
        .cam_ready    (cam_ready),
        .cfg_error    (cfg_error),
        .frame_enable (frame_enable)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int tbl_index(input logic [7:0] a);
        int r;
        r = -1;
        for (int i = 0; i < NREG; i++) begin
            if (tbl[i][15:8] == a) r = i;
        end
        return r;
    endfunction

    // Expected transaction list: every entry in order, failed attempts repeated
    // until success or until RETRY_MAX extra attempts are used up.
    task automatic build_expected();
        txn_t t;
        int   nf, wn, att;
        bit   ok, fail;
`ifdef CAM_CFG_READBACK_EN
        int   bf, rb;
`endif
        exp_q.delete();
        exp_err = 1'b0;
        for (int i = 0; i < NREG && !exp_err; i++) begin
            nf  = (i == nack_idx) ? nack_cnt : 0;
            wn  = 0;
            att = 0;
            ok  = 1'b0;
`ifdef CAM_CFG_READBACK_EN
            bf  = (i == bad_idx) ? bad_cnt : 0;
            rb  = 0;
`endif
            while (!ok && !exp_err) begin
                fail   = 1'b0;
                t.rd   = 1'b0;
                t.addr = tbl[i][15:8];
                t.data = tbl[i][7:0];
                exp_q.push_back(t);
                if (wn < nf) begin
                    wn++;
                    fail = 1'b1;
                end
`ifdef CAM_CFG_READBACK_EN
                else begin
                    t.rd = 1'b1;
                    exp_q.push_back(t);
                    if (rb < bf) begin
                        rb++;
                        fail = 1'b1;
                    end
                end
`endif
                if (!fail) ok = 1'b1;
                else if (att == RETRY_MAX) exp_err = 1'b1;
                else att++;
            end
        end
    endtask

    // I2C master model: completion pulse with scripted NACK / read data
    task automatic respond(input txn_t t);
        int idx;
        idx = tbl_index(t.addr);
        i2c_done = 1'b1;
        if (idx >= 0) begin
`ifdef CAM_CFG_READBACK_EN
            if (t.rd) begin
                i2c_rdata = tbl[idx][7:0] ^ ((idx == bad_idx && rd_seen[idx] < bad_cnt) ? 8'hA5 : 8'h00);
                rd_seen[idx]++;
            end else
`endif
            begin
                if (idx == nack_idx && wr_seen[idx] < nack_cnt) i2c_nack = 1'b1;
                wr_seen[idx]++;
            end
        end
    endtask

    // Called at a negedge where the DUT has just entered SETTLE with a cleared counter.
    task automatic run_cfg(input string tag, input int start_at, input int reset_at, input bit spurious);
        int   cyc, ntx, wait_cnt, quiet, ve_gap;
        bit   in_tx, just_done, aborted, stable;
        txn_t cur;
        cyc = 0; ntx = 0; wait_cnt = 0;
        in_tx = 1'b0; just_done = 1'b0; aborted = 1'b0; stable = 1'b1;
        build_expected();
        foreach (wr_seen[i]) wr_seen[i] = 0;
`ifdef CAM_CFG_READBACK_EN
        foreach (rd_seen[i]) rd_seen[i] = 0;
`endif
        while (1) begin
            @(negedge clk);
            cyc++;
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            start    = 1'b0;
            if (just_done) begin
                check({tag, "_req_fall"}, i2c_req, 1'b0);
                just_done = 1'b0;
            end else if (spurious && cyc == 5) begin
                i2c_done = 1'b1;
            end
            if (in_tx) begin
                if (i2c_req !== 1'b1 || i2c_reg !== cur.addr || i2c_wdata !== cur.data
`ifdef CAM_CFG_READBACK_EN
                    || i2c_rd !== cur.rd
`endif
                   ) stable = 1'b0;
                wait_cnt--;
                if (wait_cnt == 0) begin
                    respond(cur);
                    in_tx = 1'b0;
                    just_done = 1'b1;
                    ntx++;
                end
            end else if (i2c_req === 1'b1) begin
                cur.addr = i2c_reg;
                cur.data = i2c_wdata;
`ifdef CAM_CFG_READBACK_EN
                cur.rd   = i2c_rd;
`else
                cur.rd   = 1'b0;
`endif
                if (ntx == 0) check({tag, "_first_req_cycle"}, cyc, SETTLE + 1);
                check({tag, "_dev"}, i2c_dev, DEV);
                if (ntx < exp_q.size()) check({tag, "_txn"}, cur, exp_q[ntx]);
                else check({tag, "_txn_count_extra"}, ntx + 1, exp_q.size());
                if (ntx == reset_at) begin
                    res = 1'b1;
                    #1;
                    check({tag, "_req_async_drop"}, i2c_req, 1'b0);
                    check({tag, "_busy_in_reset"}, busy, 1'b0);
                    aborted = 1'b1;
                    break;
                end
                if (ntx == start_at) start = 1'b1;
                in_tx = 1'b1;
                wait_cnt = $urandom_range(1, 25);
            end
            if (!in_tx && !just_done && ntx >= exp_q.size()) break;
            if (cyc > BUDGET) begin
                check({tag, "_timeout_cycles"}, cyc, BUDGET);
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            check({tag, "_txn_count"}, ntx, exp_q.size());
            check({tag, "_fields_stable"}, stable, 1'b1);
            quiet = 0;
            repeat (20) begin
                @(negedge clk);
                if (i2c_req) quiet++;
            end
            check({tag, "_no_extra_req"}, quiet, 0);
            if (exp_err) begin
                check({tag, "_cfg_error"}, cfg_error, 1'b1);
                check({tag, "_frame_enable"}, frame_enable, 1'b0);
                check({tag, "_cam_ready"}, cam_ready, 1'b0);
                check({tag, "_busy"}, busy, 1'b0);
            end else begin
                for (int e = 1; e <= FSKIP + 1; e++) begin
                    ve_gap = $urandom_range(3, 10);
                    repeat (ve_gap) @(negedge clk);
                    vsync = 1'b1;
                    @(negedge clk);
                    check({tag, "_fe_after_vsync"}, frame_enable, (e == FSKIP + 1));
                    check({tag, "_ready_after_vsync"}, cam_ready, (e == FSKIP + 1));
                    ve_gap = $urandom_range(1, 4);
                    repeat (ve_gap) @(negedge clk);
                    vsync = 1'b0;
                end
                check({tag, "_busy_done"}, busy, 1'b0);
                check({tag, "_cfg_error"}, cfg_error, 1'b0);
                check({tag, "_fe_hold"}, frame_enable, 1'b1);
            end
        end
    endtask

    task automatic pulse_start(input string tag);
        int gap;
        gap = $urandom_range(1, 5);
        repeat (gap) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_ready_clr"}, cam_ready, 1'b0);
        check({tag, "_err_clr"}, cfg_error, 1'b0);
        check({tag, "_fe_clr"}, frame_enable, 1'b0);
        check({tag, "_busy_set"}, busy, 1'b1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req", i2c_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cam_ready, 1'b0);
        check("rst_err", cfg_error, 1'b0);
        check("rst_fe", frame_enable, 1'b0);
        check("rst_dev", i2c_dev, DEV);
        check("rst_reg", i2c_reg, 8'h00);
        check("rst_wdata", i2c_wdata, 8'h00);
        res = 1'b0;
        #1;
        check("busy_after_release", busy, 1'b1);

        run_cfg("clean", -1, -1, 1'b0);

        pulse_start("restart_idle");
        nack_idx = 5; nack_cnt = 2;
        run_cfg("nack5", 3, -1, 1'b0);

        pulse_start("restart_idle2");
        nack_idx = 7; nack_cnt = 4;
        run_cfg("nack7_err", -1, -1, 1'b0);

        pulse_start("restart_err");
        nack_idx = -1; nack_cnt = 0;
        run_cfg("after_err", -1, -1, 1'b1);

        pulse_start("restart_pre_rst");
        run_cfg("rst_mid", -1, 4, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_mid_hold_req", i2c_req, 1'b0);
        res = 1'b0;
        run_cfg("after_rst", -1, -1, 1'b0);

`ifdef CAM_CFG_READBACK_EN
        pulse_start("restart_rb");
        bad_idx = 3; bad_cnt = 1;
        run_cfg("readback_bad3", -1, -1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
